// File: rtl/sram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_arbiter_pkg
//   Shared definitions for the two-port SRAM arbiter: the arbitration FSM
//   state encoding and the read/write encoding used on every rw signal.
// ---------------------------------------------------------------------------
package sram_arbiter_pkg;

  // IDLE     : no transaction; picks a port when any enable is seen
  // GRANT_A/B: memory request in flight for the named port
  // DONE     : port ready held until that port drops its enable
  // RELEASE  : memory enable held low until the memory drops its ready
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_A = 3'd1,
    GRANT_B = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage : sram_arbiter_pkg

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Arbitrates two request ports (A and B) onto one SRAM-style memory port.
//   Ties are broken round-robin, a wait counter force-completes a stuck
//   memory access, and the memory enable is always dropped between
//   transactions so the memory can rearm.
//
// Parameters
//   TIMEOUT       memory wait cycles before a transaction is force-completed
//   TIMEOUT_DATA  read data returned for a timed-out read
//
// Ports
//   i_clock                       clock, rising edge
//   i_reset                       asynchronous active-high reset
//   i_px_enable                   port request, held until o_px_ready
//   i_px_rw                       0 = read, 1 = write
//   i_px_address / i_px_wdata     byte address / write data
//   o_px_rdata                    registered read data (changes on completion)
//   o_px_ready                    completion, held while i_px_enable stays high
//   o_mem_enable                  memory request
//   o_mem_rw/_address/_wdata      registered copy of the granted request
//   i_mem_rdata / i_mem_ready     memory read data / completion
//   o_timeout                     one-cycle pulse on a forced completion
//   (x = a or b)
// ---------------------------------------------------------------------------
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 1023,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  // port A
  input  logic        i_pa_enable,
  input  logic        i_pa_rw,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pa_wdata,
  output logic [31:0] o_pa_rdata,
  output logic        o_pa_ready,
  // port B
  input  logic        i_pb_enable,
  input  logic        i_pb_rw,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic [31:0] o_pb_rdata,
  output logic        o_pb_ready,
  // memory
  output logic        o_mem_enable,
  output logic        o_mem_rw,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  // status
  output logic        o_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  // Value the counter holds during the TIMEOUT-th wait cycle.
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic          last_b;        // 1: port B was granted last (also current owner)
  logic [CW-1:0] wait_count;

  logic          owner_enable;
  logic          grant_a;
  logic          grant_b;
  logic          finish;
  logic          timed_out;
  logic [31:0]   finish_data;

  // The flag only moves on a grant, so while a transaction is in flight or
  // in DONE it names the port being served.
  assign owner_enable = last_b ? i_pb_enable : i_pa_enable;

  // --------------------------------------------------------------------------
  // Next-state and per-cycle strobes
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;

    unique case (state)
      IDLE: begin
        // A wins when alone, or on a tie when B was served last.
        if (i_pa_enable && (!i_pb_enable || last_b)) begin
          grant_a    = 1'b1;
          state_next = GRANT_A;
        end else if (i_pb_enable) begin
          grant_b    = 1'b1;
          state_next = GRANT_B;
        end
      end

      GRANT_A, GRANT_B: begin
        // Abort takes precedence: a port that gave up gets no ready and any
        // result arriving afterwards is ignored.
        if (!owner_enable) begin
          state_next = RELEASE;
        end else if (i_mem_ready) begin
          finish     = 1'b1;
          state_next = DONE;
        end else if (wait_count == WAIT_LAST) begin
          finish     = 1'b1;
          timed_out  = 1'b1;
          state_next = DONE;
        end
      end

      DONE: begin
        if (!owner_enable) state_next = RELEASE;
      end

      RELEASE: begin
        // Wait for the memory to retire its ready before arming it again.
        if (!i_mem_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign finish_data = timed_out ? TIMEOUT_DATA : i_mem_rdata;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      last_b        <= 1'b1;
      wait_count    <= '0;
      o_mem_rw      <= RW_READ;
      o_mem_address <= '0;
      o_mem_wdata   <= '0;
      o_pa_rdata    <= '0;
      o_pb_rdata    <= '0;
      o_timeout     <= 1'b0;
    end else begin
      o_timeout <= timed_out;

      if (grant_a) begin
        last_b        <= 1'b0;
        wait_count    <= '0;
        o_mem_rw      <= i_pa_rw;
        o_mem_address <= i_pa_address;
        o_mem_wdata   <= i_pa_wdata;
      end else if (grant_b) begin
        last_b        <= 1'b1;
        wait_count    <= '0;
        o_mem_rw      <= i_pb_rw;
        o_mem_address <= i_pb_address;
        o_mem_wdata   <= i_pb_wdata;
      end else if (o_mem_enable) begin
        wait_count <= wait_count + CW'(1);
      end

      // Read data only moves on a completed read; writes (including
      // timed-out ones) leave it untouched.
      if (finish && (o_mem_rw == RW_READ)) begin
        if (last_b) o_pb_rdata <= finish_data;
        else        o_pa_rdata <= finish_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded straight from the state register
  // --------------------------------------------------------------------------
  assign o_mem_enable = (state == GRANT_A) || (state == GRANT_B);
  assign o_pa_ready   = (state == DONE) && !last_b;
  assign o_pb_ready   = (state == DONE) &&  last_b;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter: a table of single-port
//   transactions plus hand-written sequences for ties, timeout, reset during
//   a transaction and abort. A small memory model answers after a
//   programmable latency: ready rises after the model has seen o_mem_enable
//   high on `latency` rising edges.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int unsigned TB_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pa_enable = 1'b0, pa_rw = 1'b0;
  logic [31:0] pa_address = '0, pa_wdata = '0, pa_rdata;
  logic        pa_ready;
  logic        pb_enable = 1'b0, pb_rw = 1'b0;
  logic [31:0] pb_address = '0, pb_wdata = '0, pb_rdata;
  logic        pb_ready;
  logic        mem_enable, mem_rw;
  logic [31:0] mem_address, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .TIMEOUT      (TB_TIMEOUT),
    .TIMEOUT_DATA (32'hDEAD_BEEF)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_pa_enable   (pa_enable),
    .i_pa_rw       (pa_rw),
    .i_pa_address  (pa_address),
    .i_pa_wdata    (pa_wdata),
    .o_pa_rdata    (pa_rdata),
    .o_pa_ready    (pa_ready),
    .i_pb_enable   (pb_enable),
    .i_pb_rw       (pb_rw),
    .i_pb_address  (pb_address),
    .i_pb_wdata    (pb_wdata),
    .o_pb_rdata    (pb_rdata),
    .o_pb_ready    (pb_ready),
    .o_mem_enable  (mem_enable),
    .o_mem_rw      (mem_rw),
    .o_mem_address (mem_address),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata),
    .i_mem_ready   (mem_ready),
    .o_timeout     (timeout)
  );

  // ---------------------------------------------------------------- memory
  int          mem_latency = 1;
  bit          mem_stall   = 1'b0;
  int          mem_cnt;
  logic [31:0] mem [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_cnt   <= 0;
      mem_rdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[64] <= 32'h1234_5678;   // 0x100
      mem[48] <= 32'h5555_AAAA;   // 0x0C0
    end else if (!mem_enable) begin
      mem_ready <= 1'b0;
      mem_cnt   <= 0;
    end else if (!mem_ready && !mem_stall) begin
      if (mem_cnt >= mem_latency - 1) begin
        mem_ready <= 1'b1;
        if (mem_rw == RW_WRITE) mem[mem_address[9:2]] <= mem_wdata;
        else                    mem_rdata <= mem[mem_address[9:2]];
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic drive(input bit port_b, input logic en, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port_b) begin
      pb_enable = en; pb_rw = rw; pb_address = addr; pb_wdata = wdata;
    end else begin
      pa_enable = en; pa_rw = rw; pa_address = addr; pa_wdata = wdata;
    end
  endtask

  // sel: 0 = A, 1 = B, 2 = either. Bounded by budget cycles.
  task automatic wait_ready(input int sel, input int budget, output int cycles);
    bit hit;
    hit    = 1'b0;
    cycles = 0;
    while (!hit && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      case (sel)
        0:       hit = pa_ready;
        1:       hit = pb_ready;
        default: hit = pa_ready | pb_ready;
      endcase
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One single-port transaction; cycles counted from the enable cycle.
  task automatic run_txn(input string name, input bit port_b, input logic rw,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int latency, input int exp_cycles,
                         input logic [31:0] exp_rdata);
    int  cycles;
    bit  hit;
    mem_latency = latency;
    @(posedge clk); #1;
    drive(port_b, 1'b1, rw, addr, wdata);
    cycles = 0;
    hit    = 1'b0;
    while (!hit && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) begin
        check({name, " mem_enable at grant"}, 32'(mem_enable), 32'd1);
        check({name, " mem_address"}, mem_address, addr);
        check({name, " mem_rw"}, 32'(mem_rw), 32'(rw));
        if (rw == RW_WRITE) check({name, " mem_wdata"}, mem_wdata, wdata);
      end
      hit = port_b ? pb_ready : pa_ready;
    end
    check({name, " latency"}, 32'(cycles), 32'(exp_cycles));
    check({name, " rdata"}, port_b ? pb_rdata : pa_rdata, exp_rdata);
    check({name, " mem_enable in DONE"}, 32'(mem_enable), 32'd0);
    check({name, " other ready"}, 32'(port_b ? pa_ready : pb_ready), 32'd0);
    drive(port_b, 1'b0, rw, addr, wdata);
    @(posedge clk); #1;
    check({name, " ready drop"}, 32'(port_b ? pb_ready : pa_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit          port_b;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          latency;
    int          exp_cycles;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cycles;
    int pa_hits;
    int early_to;

    // port_b, rw, addr, wdata, latency, exp_cycles, exp_rdata
    vecs[0] = '{1'b0, RW_READ,  32'h100, 32'h0,         4, 6, 32'h1234_5678};
    vecs[1] = '{1'b1, RW_WRITE, 32'h040, 32'hCAFE_F00D, 2, 4, 32'h0};
    vecs[2] = '{1'b0, RW_READ,  32'h040, 32'h0,         3, 5, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, RW_READ,  32'h100, 32'h0,         1, 3, 32'h1234_5678};
    vecs[4] = '{1'b0, RW_WRITE, 32'h080, 32'hA5A5_5A5A, 5, 7, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, RW_READ,  32'h080, 32'h0,         6, 8, 32'hA5A5_5A5A};
    vecs[6] = '{1'b0, RW_READ,  32'h0C0, 32'h0,         2, 4, 32'h5555_AAAA};

    // ---- reset state
    #2 rst = 1'b1;
    #3;
    check("rst mem_enable", 32'(mem_enable), 32'd0);
    check("rst pa_ready",   32'(pa_ready),   32'd0);
    check("rst pb_ready",   32'(pb_ready),   32'd0);
    check("rst timeout",    32'(timeout),    32'd0);
    check("rst pa_rdata",   pa_rdata,        32'd0);
    check("rst pb_rdata",   pb_rdata,        32'd0);
    check("rst mem_addr",   mem_address,     32'd0);
    check("rst mem_wdata",  mem_wdata,       32'd0);
    check("rst mem_rw",     32'(mem_rw),     32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- table of single-port transactions
    foreach (vecs[i]) begin
      run_txn($sformatf("vec%0d", i), vecs[i].port_b, vecs[i].rw,
              vecs[i].addr, vecs[i].wdata, vecs[i].latency,
              vecs[i].exp_cycles, vecs[i].exp_rdata);
    end

    // ---- ties straight after reset: A, B, A, B
    pulse_reset();
    mem_latency = 2;
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 1'b1, RW_READ, 32'h100, 32'h0);
      drive(1'b1, 1'b1, RW_READ, 32'h0C0, 32'h0);
      wait_ready(2, 50, cycles);
      check($sformatf("tie%0d first is A", r), 32'(pa_ready), 32'd1);
      check($sformatf("tie%0d B waits", r), 32'(pb_ready), 32'd0);
      check($sformatf("tie%0d A rdata", r), pa_rdata, 32'h1234_5678);
      check($sformatf("tie%0d B rdata held", r), pb_rdata,
            (r == 0) ? 32'h0 : 32'h5555_AAAA);
      drive(1'b0, 1'b0, RW_READ, 32'h100, 32'h0);
      wait_ready(1, 50, cycles);
      check($sformatf("tie%0d second is B", r), 32'(pb_ready), 32'd1);
      check($sformatf("tie%0d B address", r), mem_address, 32'h0C0);
      check($sformatf("tie%0d B rdata", r), pb_rdata, 32'h5555_AAAA);
      drive(1'b1, 1'b0, RW_READ, 32'h0C0, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end

    // ---- timeout: memory never answers
    mem_stall = 1'b1;
    drive(1'b0, 1'b1, RW_READ, 32'h100, 32'h0);
    cycles   = 0;
    early_to = 0;
    while (!pa_ready && cycles < 60) begin
      @(posedge clk); #1;
      cycles++;
      if (timeout && !pa_ready) early_to++;
    end
    check("timeout latency", 32'(cycles), 32'(TB_TIMEOUT + 1));
    check("timeout early pulse", 32'(early_to), 32'd0);
    check("timeout pulse", 32'(timeout), 32'd1);
    check("timeout rdata", pa_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("timeout one cycle", 32'(timeout), 32'd0);
    check("timeout ready held", 32'(pa_ready), 32'd1);
    drive(1'b0, 1'b0, RW_READ, 32'h100, 32'h0);
    mem_stall = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // ---- reset in the middle of GRANT_B
    mem_latency = 6;
    drive(1'b1, 1'b1, RW_READ, 32'h040, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("midrst mem_enable before", 32'(mem_enable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst mem_enable", 32'(mem_enable), 32'd0);
    check("midrst pb_ready",   32'(pb_ready),   32'd0);
    check("midrst pa_rdata",   pa_rdata,        32'd0);
    check("midrst pb_rdata",   pb_rdata,        32'd0);
    check("midrst mem_addr",   mem_address,     32'd0);
    check("midrst timeout",    32'(timeout),    32'd0);
    drive(1'b1, 1'b0, RW_READ, 32'h040, 32'h0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    pa_hits = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (pb_ready || mem_enable) pa_hits++;
    end
    check("midrst stays idle", 32'(pa_hits), 32'd0);
    run_txn("after rst", 1'b0, RW_READ, 32'h100, 32'h0, 4, 6, 32'h1234_5678);

    // ---- abort by A with B pending
    mem_latency = 6;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, RW_READ, 32'h100, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, RW_READ, 32'h0C0, 32'h0);
    check("abort mem_enable", 32'(mem_enable), 32'd1);
    check("abort mem_addr A", mem_address, 32'h100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, RW_READ, 32'h100, 32'h0);
    @(posedge clk); #1;
    check("abort mem_enable drop", 32'(mem_enable), 32'd0);
    pa_hits = 0;
    cycles  = 0;
    while (!pb_ready && cycles < 40) begin
      if (pa_ready) pa_hits++;
      @(posedge clk); #1;
      cycles++;
    end
    check("abort no A ready", 32'(pa_hits), 32'd0);
    check("abort B served", 32'(pb_ready), 32'd1);
    check("abort B rdata", pb_rdata, 32'h5555_AAAA);
    check("abort B address", mem_address, 32'h0C0);
    check("abort A rdata held", pa_rdata, 32'h1234_5678);
    drive(1'b1, 1'b0, RW_READ, 32'h0C0, 32'h0);
    @(posedge clk); #1;
    check("abort B ready drop", 32'(pb_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_sram_arbiter

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 1023, max memory wait cycles before a transaction is force-completed.
REQ-002 Parameter: TIMEOUT_DATA, default 32'hDEAD_BEEF, read data returned on a timed-out read.
REQ-003 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_pa_enable / i_pb_enable  in  1  port A / port B request; held high until that port's ready is seen.
REQ-006 i_pa_rw / i_pb_rw  in  1  0 = read, 1 = write.
REQ-007 i_pa_address / i_pb_address  in  32  byte address.
REQ-008 i_pa_wdata / i_pb_wdata  in  32  write data.
REQ-009 o_pa_rdata / o_pb_rdata  out  32  registered read data.
REQ-010 o_pa_ready / o_pb_ready  out  1  transaction complete; held while that port's enable stays high.
REQ-011 o_mem_enable  out  1  memory request; must drop after each completion so the memory rearms.
REQ-012 o_mem_rw / o_mem_address / o_mem_wdata  out  1/32/32  registered copies of the granted port's request.
REQ-013 i_mem_rdata / i_mem_ready  in  32/1  memory read data and completion flag.
REQ-014 o_timeout  out  1  one-cycle pulse when a transaction is force-completed.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT_A, GRANT_B, DONE and RELEASE.
REQ-016 IDLE, only one enable high: grant that port; both high: grant the port not granted last (round-robin).
REQ-017 On grant, the block SHALL latch rw/address/wdata into the o_mem_* registers and assert o_mem_enable in the next cycle.
REQ-018 GRANT_x: o_mem_enable stays high; i_mem_ready high -> latch i_mem_rdata into o_x_rdata on reads, assert o_x_ready, go to DONE.
REQ-019 Port request-to-ready latency SHALL be memory latency + 2 cycles; o_x_rdata changes only on completion.
REQ-020 DONE: o_mem_enable low; o_x_ready held until i_x_enable drops; then o_x_ready low and go to RELEASE.
REQ-021 RELEASE: o_mem_enable low until i_mem_ready is low; then go to IDLE, giving at least one enable-low cycle between memory transactions.
REQ-022 Abort: granted port drops enable before i_mem_ready -> o_mem_enable drops next cycle, any late result is discarded, no ready is issued, go to RELEASE.
REQ-023 Timeout: a counter cleared on grant counts cycles in GRANT_x; when it reaches TIMEOUT, o_timeout pulses for one cycle and the transaction completes as REQ-018 with rdata = TIMEOUT_DATA (writes are dropped).
REQ-024 The ungranted port SHALL see o_ready low and rdata unchanged; its request waits and needs no re-issue.
REQ-025 The last-granted flag SHALL update only on grant.

Reset
REQ-026 On i_reset high, immediately: FSM = IDLE; o_mem_enable, o_pa_ready, o_pb_ready, o_timeout = 0; o_*_rdata, o_mem_address, o_mem_wdata = 0; o_mem_rw = 0; counter = 0; last-granted = B, so A wins the first tie.
REQ-027 Reset during a transaction SHALL abandon it with no ready pulse; after reset releases, the block waits in IDLE for a fresh enable.

Structure
REQ-028 Package sram_arbiter_pkg SHALL hold the state enum and the 0/1 rw encoding constants.
REQ-029 The design SHALL be a single flat module with no sub-module; port muxing is inline.

Verification
REQ-030 A read 0x100, memory latency 4, rdata 0x1234_5678 -> o_pa_ready at cycle 6, o_pa_rdata = 0x1234_5678, o_mem_enable low while in DONE.
REQ-031 A and B both request in the same cycle after reset -> A is served first and B next; repeated ties alternate A, B, A, B.
REQ-032 B writes 0xCAFE_F00D to 0x40, then A reads 0x40 -> A gets 0xCAFE_F00D, with o_mem_enable low for at least 1 cycle between the two transactions.
REQ-033 Memory never readies, TIMEOUT = 15 -> o_timeout pulses after 15 wait cycles, o_pa_rdata = 0xDEAD_BEEF, o_pa_ready high.
REQ-034 Reset asserted mid-GRANT_B -> all outputs 0 immediately; no o_pb_ready; next A request served normally.
REQ-035 A drops enable during the memory wait -> o_mem_enable falls next cycle, no o_pa_ready, B pending is served after RELEASE.
